// File: rtl/detector_pkg.sv
// Shared types and Q2.14 constants for the threshold-crossing detector.
package detector_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int ONE           = 16384;
  localparam int HALF          = ONE / 2;
  localparam int DEF_THRESH_HI = 9830;
  localparam int DEF_THRESH_LO = 6554;
  localparam int DEF_FILT_LEN  = 1;
  localparam int FILT_LEN_MAX  = 255;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    LVL_LOW  = 1'b0,
    LVL_HIGH = 1'b1
  } level_e;

  function automatic int cnt_width(input int filt_len);
    return $clog2(filt_len + 1);
  endfunction

endpackage

// File: rtl/detector_debounce.sv
// Consecutive-sample debounce counter; raises flip on the FILT_LEN-th qualifying sample.
module detector_debounce
  import detector_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic qualify,
  output logic flip
);

  localparam int              CNT_W = cnt_width(FILT_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILT_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: defaults first so every path assigns cnt_d and flip; no latch is inferred.
    cnt_d = cnt_q;
    flip  = 1'b0;
    if (en) begin
      if (qualify) begin
        if (cnt_q == LAST) begin
          flip  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop updates from pre-edge values.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/detector.sv
// Hysteresis threshold detector: signed compares, debounced level, one-cycle edge pulses.
module detector
  import detector_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int THRESH_HI = DEF_THRESH_HI,
  parameter int THRESH_LO = DEF_THRESH_LO,
  parameter int FILT_LEN  = DEF_FILT_LEN
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_in,
  output logic                     rising_edge,
  output logic                     falling_edge,
  output logic                     level
);

  if (THRESH_HI <= THRESH_LO) begin : g_bad_thresh
    $error("detector: THRESH_HI must be strictly greater than THRESH_LO");
  end
  if (FILT_LEN < 1 || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt
    $error("detector: FILT_LEN must be in 1..255");
  end

  localparam logic signed [DATA_W-1:0] HI_S = DATA_W'(THRESH_HI);
  localparam logic signed [DATA_W-1:0] LO_S = DATA_W'(THRESH_LO);

  level_e level_q, level_d;
  logic   rise_q, rise_d;
  logic   fall_q, fall_d;
  logic   qualify;
  logic   flip;

  // Only the threshold on the far side of the band can qualify a sample.
  assign qualify = (level_q == LVL_HIGH) ? (a_in <= LO_S) : (a_in >= HI_S);

  detector_debounce #(
    .FILT_LEN(FILT_LEN)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .qualify(qualify),
    .flip   (flip)
  );

  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (flip) begin
      if (level_q == LVL_LOW) begin
        level_d = LVL_HIGH;
        rise_d  = 1'b1;
      end else begin
        level_d = LVL_LOW;
        fall_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= LVL_LOW;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level        = (level_q == LVL_HIGH);
  assign rising_edge  = rise_q;
  assign falling_edge = fall_q;

endmodule

// File: tb/tb_detector.sv
// Bench for detector: three instances (FILT_LEN 1, 3, 2) share stimulus and are checked against a counting model.
module tb_detector;

  localparam int FL [3] = '{1, 3, 2};

  logic               clk;
  logic               rst_n;
  logic               en;
  logic signed [15:0] a_in;

  logic r1, f1, l1, r3, f3, l3, r2, f2, l2;
  logic [2:0] obs [3];

  assign obs[0] = {r1, f1, l1};
  assign obs[1] = {r3, f3, l3};
  assign obs[2] = {r2, f2, l2};

  detector #(.FILT_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in),
    .rising_edge(r1), .falling_edge(f1), .level(l1)
  );
  detector #(.FILT_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in),
    .rising_edge(r3), .falling_edge(f3), .level(l3)
  );
  detector #(.FILT_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .a_in(a_in),
    .rising_edge(r2), .falling_edge(f2), .level(l2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference: level flips once FILT_LEN enabled samples in a row lie beyond the opposite threshold.
  bit m_lvl  [3];
  bit m_rise [3];
  bit m_fall [3];
  int run    [3];

  function automatic logic [2:0] exp_vec(input int k);
    return {m_rise[k], m_fall[k], m_lvl[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_lvl[k] = 0; m_rise[k] = 0; m_fall[k] = 0; run[k] = 0;
    end
  endtask

  task automatic step(input logic signed [15:0] s, input logic e);
    int  sv;
    bit  q;
    a_in = s;
    en   = e;
    @(posedge clk);
    #1;
    sv = int'(s);
    for (int k = 0; k < 3; k++) begin
      m_rise[k] = 0;
      m_fall[k] = 0;
      if (e) begin
        q = m_lvl[k] ? (sv <= 6554) : (sv >= 9830);
        if (q) begin
          run[k]++;
          if (run[k] == FL[k]) begin
            if (m_lvl[k]) m_fall[k] = 1; else m_rise[k] = 1;
            m_lvl[k] = !m_lvl[k];
            run[k]   = 0;
          end
        end else begin
          run[k] = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a_in = 16'sd16384;
    en   = 1'b1;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 3'b000) begin
        errors++;
        $display("FAIL reset dut_filt%0d: got r/f/l=%b want 000", FL[k], obs[k]);
      end
    end
  endtask

  task automatic test_toggle();
    int rises = 0;
    int falls = 0;
    do_reset();
    for (int t = 0; t < 20; t++) begin
      for (int c = 0; c < 10; c++) begin
        step((t % 2 == 0) ? 16'sd16384 : 16'sd0, 1'b1);
        rises += int'(r1);
        falls += int'(f1);
        checks++;
        if (obs[0] !== exp_vec(0)) begin
          errors++;
          $display("FAIL toggle t=%0d c=%0d: got r/f/l=%b want %b", t, c, obs[0], exp_vec(0));
        end
      end
    end
    checks++;
    if (rises !== 10 || falls !== 10) begin
      errors++;
      $display("FAIL toggle_count: got rises=%0d falls=%0d want 10/10", rises, falls);
    end
  endtask

  task automatic test_band();
    step(16'sd16384, 1'b1);
    step(16'sd16384, 1'b1);
    for (int c = 0; c < 20; c++) begin
      step(16'sd8192, 1'b1);
      checks++;
      if (obs[0] !== 3'b001) begin
        errors++;
        $display("FAIL band c=%0d: got r/f/l=%b want 001", c, obs[0]);
      end
    end
  endtask

  task automatic test_filt3();
    logic signed [15:0] seq  [8] = '{16'sd0, 16'sd0, 16'sd16384, 16'sd16384, 16'sd0,
                                    16'sd16384, 16'sd16384, 16'sd16384};
    logic [2:0]         want [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                    3'b000, 3'b000, 3'b101};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(seq[i], 1'b1);
      checks++;
      if (obs[1] !== want[i]) begin
        errors++;
        $display("FAIL filt3 i=%0d: got r/f/l=%b want %b", i, obs[1], want[i]);
      end
    end
  endtask

  task automatic test_enable();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(16'sd16384, 1'b0);
      checks++;
      if (obs[0] !== 3'b000) begin
        errors++;
        $display("FAIL en_low c=%0d: got r/f/l=%b want 000", c, obs[0]);
      end
    end
    step(16'sd16384, 1'b1);
    checks++;
    if (obs[0] !== 3'b101) begin
      errors++;
      $display("FAIL en_first: got r/f/l=%b want 101", obs[0]);
    end
    do_reset();
    step(16'sd16384, 1'b1);
    step(16'sd16384, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step(16'sd16384, 1'b0);
      checks++;
      if (obs[1] !== 3'b000) begin
        errors++;
        $display("FAIL en_hold c=%0d: got r/f/l=%b want 000", c, obs[1]);
      end
    end
    step(16'sd16384, 1'b1);
    checks++;
    if (obs[1] !== 3'b101) begin
      errors++;
      $display("FAIL en_resume: got r/f/l=%b want 101", obs[1]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(16'sd16384, 1'b1);
    checks++;
    if (obs[0] !== 3'b101 || obs[2] !== 3'b000) begin
      errors++;
      $display("FAIL rst_pre: got f1=%b f2=%b want 101/000", obs[0], obs[2]);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 3'b000) begin
        errors++;
        $display("FAIL rst_async dut_filt%0d: got r/f/l=%b want 000", FL[k], obs[k]);
      end
    end
    #2;
    rst_n = 1'b1;
    step(16'sd16384, 1'b1);
    checks++;
    if (obs[2] !== 3'b000) begin
      errors++;
      $display("FAIL rst_fresh1: got r/f/l=%b want 000", obs[2]);
    end
    step(16'sd16384, 1'b1);
    checks++;
    if (obs[2] !== 3'b101) begin
      errors++;
      $display("FAIL rst_fresh2: got r/f/l=%b want 101", obs[2]);
    end
  endtask

  task automatic test_boundary();
    logic signed [15:0] seq  [10] = '{16'sd9829, 16'sd9829, 16'sd9829, 16'sd9830, 16'sd9830,
                                     16'sd6555, 16'sd6555, 16'sd6555, 16'sd6554, 16'sd6554};
    logic [2:0]         want [10] = '{3'b000, 3'b000, 3'b000, 3'b101, 3'b001,
                                     3'b001, 3'b001, 3'b001, 3'b010, 3'b000};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(seq[i], 1'b1);
      checks++;
      if (obs[0] !== want[i]) begin
        errors++;
        $display("FAIL boundary i=%0d a_in=%0d: got r/f/l=%b want %b", i, seq[i], obs[0], want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] s;
    int                 hold;
    logic               e;
    do_reset();
    s    = 16'sd0;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 5))
          0:       s = 16'($urandom);
          1:       s = 16'(9830 + int'($urandom_range(0, 4)) - 2);
          2:       s = 16'(6554 + int'($urandom_range(0, 4)) - 2);
          3:       s = 16'sd16384;
          4:       s = 16'sd0;
          default: s = ($urandom_range(0, 1) == 0) ? -16'sd32768 : 16'sd32767;
        endcase
        hold = int'($urandom_range(1, 4));
      end
      hold--;
      e = ($urandom_range(0, 9) != 0);
      step(s, e);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL random c=%0d dut_filt%0d a_in=%0d en=%b: got r/f/l=%b want %b",
                   c, FL[k], s, e, obs[k], exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a_in  = 16'sd0;
    model_reset();
    #12;
    test_reset();
    test_toggle();
    test_band();
    test_filt3();
    test_enable();
    test_reset_mid();
    test_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
